// File: rtl/de_stall_ctrl.sv
// D->E stall/flush controller: operand Tuse/Tnew hazards plus a mult/div busy counter.
// Optional stall-cycle counter enabled by defining DE_STALL_PERF_EN.
module de_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic        D_use_rs,
  input  logic        D_use_rt,
  input  logic [2:0]  D_Tuse_rs,
  input  logic [2:0]  D_Tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_wa,
  input  logic [2:0]  E_Tnew,
  input  logic [4:0]  M_wa,
  input  logic [2:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        de_clr,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic             hz_rs;
  logic             hz_rt;
  logic             hz_md;
  logic             stall;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    hz_rs = D_use_rs && (D_rs_addr != 5'd0) &&
            (((E_wa == D_rs_addr) && (E_Tnew > D_Tuse_rs)) ||
             ((M_wa == D_rs_addr) && (M_Tnew > D_Tuse_rs)));
    hz_rt = D_use_rt && (D_rt_addr != 5'd0) &&
            (((E_wa == D_rt_addr) && (E_Tnew > D_Tuse_rt)) ||
             ((M_wa == D_rt_addr) && (M_Tnew > D_Tuse_rt)));
  end

  // While reset is high the stale counter is masked so busy follows the start pulse alone.
  assign md_busy = E_md_start | ((cnt_q != '0) & ~reset);
  assign hz_md   = D_md & md_busy;
  assign stall   = (hz_rs | hz_rt | hz_md) & ~reset;

  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_en  = 1'b1;
  assign de_clr = stall;

  always_comb begin
    cnt_d = cnt_q;
    if (E_md_start) begin
      cnt_d = E_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef DE_STALL_PERF_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= 32'h0;
    end else if (stall) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_de_stall_ctrl.sv
// Bench for de_stall_ctrl: hazard vector table plus multi-cycle MDU/reset sequences.
module tb_de_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic        D_use_rs, D_use_rt, D_md, E_md_start, E_md_is_div;
  logic [2:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        pc_en, fd_en, de_en, de_clr, md_busy;
  logic [31:0] stall_count;

  de_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md(D_md), .E_wa(E_wa), .E_Tnew(E_Tnew), .M_wa(M_wa), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .de_clr(de_clr),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, ewa, mwa;
    logic       use_rs, use_rt, md, start, is_div, rst;
    logic [2:0] tuse_rs, tuse_rt, etnew, mtnew;
    logic       exp_stall, exp_busy;
    string      name;
  } vec_t;

  typedef struct {
    logic [4:0]  outs;
    logic [31:0] sc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_sc = 32'h0;
  vec_t        tbl[11];

  function automatic vec_t hz(input logic [4:0] rs, input logic use_rs, input logic [2:0] tuse_rs,
                              input logic [4:0] rt, input logic use_rt, input logic [2:0] tuse_rt,
                              input logic [4:0] ewa, input logic [2:0] etnew,
                              input logic [4:0] mwa, input logic [2:0] mtnew,
                              input logic md, input logic exp_stall, input string name);
    vec_t v;
    v.rs = rs; v.use_rs = use_rs; v.tuse_rs = tuse_rs;
    v.rt = rt; v.use_rt = use_rt; v.tuse_rt = tuse_rt;
    v.ewa = ewa; v.etnew = etnew; v.mwa = mwa; v.mtnew = mtnew;
    v.md = md; v.start = 1'b0; v.is_div = 1'b0; v.rst = 1'b0;
    v.exp_stall = exp_stall; v.exp_busy = 1'b0; v.name = name;
    return v;
  endfunction

  function automatic vec_t mdv(input logic start, input logic is_div, input logic md,
                               input logic rst, input logic exp_stall, input logic exp_busy,
                               input string name);
    vec_t v;
    v = hz(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, md, exp_stall, name);
    v.start = start; v.is_div = is_div; v.rst = rst; v.exp_busy = exp_busy;
    return v;
  endfunction

  // Drive on the falling edge, check 2ns later, state advances on the following rising edge.
  task automatic cyc(input vec_t v);
    exp_t e, got;
    @(negedge clk);
    reset = v.rst; D_rs_addr = v.rs; D_rt_addr = v.rt; D_use_rs = v.use_rs; D_use_rt = v.use_rt;
    D_Tuse_rs = v.tuse_rs; D_Tuse_rt = v.tuse_rt; D_md = v.md; E_wa = v.ewa; E_Tnew = v.etnew;
    M_wa = v.mwa; M_Tnew = v.mtnew; E_md_start = v.start; E_md_is_div = v.is_div;
    e.outs = {~v.exp_stall, ~v.exp_stall, 1'b1, v.exp_stall, v.exp_busy};
    e.sc   = exp_sc;
    e.name = v.name;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    n_vec++;
    if ({pc_en, fd_en, de_en, de_clr, md_busy} !== got.outs || stall_count !== got.sc) begin
      n_fail++;
      $display("FAIL %s: got pc/fd/de_en/clr/busy=%b count=%0d, want %b count=%0d",
               got.name, {pc_en, fd_en, de_en, de_clr, md_busy}, stall_count, got.outs, got.sc);
    end
`ifdef DE_STALL_PERF_EN
    if (v.rst) exp_sc = 32'h0;
    else if (v.exp_stall) exp_sc = exp_sc + 32'd1;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            rs  urs trs rt  urt trt ewa etn mwa mtn md stall
    tbl[0]  = hz(5,  1, 0,  0,  0, 0,  5,  2,  0,  0,  0, 1, "load_use_E");
    tbl[1]  = hz(5,  1, 0,  0,  0, 0,  0,  1,  5,  1,  0, 1, "load_use_M");
    tbl[2]  = hz(5,  1, 0,  0,  0, 0,  0,  1,  5,  0,  0, 0, "load_use_release");
    tbl[3]  = hz(0,  0, 0,  5,  1, 1,  5,  1,  0,  0,  0, 0, "forward_rt");
    tbl[4]  = hz(0,  0, 0,  0,  1, 0,  0,  2,  0,  0,  0, 0, "reg0_no_hazard");
    tbl[5]  = hz(7,  0, 0,  0,  0, 0,  7,  3,  0,  0,  0, 0, "rs_not_used");
    tbl[6]  = hz(0,  0, 0,  9,  1, 1,  0,  0,  9,  2,  0, 1, "rt_hazard_M");
    tbl[7]  = hz(3,  1, 2,  0,  0, 0,  3,  2,  0,  0,  0, 0, "tnew_eq_tuse");
    tbl[8]  = hz(31, 1, 6,  0,  0, 0, 31,  7,  0,  0,  0, 1, "tnew7_gt_tuse6");
    tbl[9]  = hz(4,  1, 0,  0,  0, 0,  5,  3,  6,  3,  0, 0, "addr_mismatch");
    tbl[10] = hz(0,  0, 0,  0,  0, 0,  0,  0,  0,  0,  1, 0, "md_idle");

    reset = 1'b1; D_rs_addr = '0; D_rt_addr = '0; D_use_rs = 0; D_use_rt = 0; D_Tuse_rs = '0;
    D_Tuse_rt = '0; D_md = 0; E_wa = '0; E_Tnew = '0; M_wa = '0; M_Tnew = '0;
    E_md_start = 0; E_md_is_div = 0;
    repeat (2) @(posedge clk);
    exp_sc = 32'h0;
    cyc(mdv(0, 0, 1, 1, 0, 0, "reset_state"));

    foreach (tbl[i]) cyc(tbl[i]);

    // Mult: busy for cycles 0..4 including the start cycle.
    cyc(mdv(1, 0, 1, 0, 1, 1, "mult_c0"));
    for (int k = 1; k < 5; k++) cyc(mdv(0, 0, 1, 0, 1, 1, $sformatf("mult_c%0d", k)));
    cyc(mdv(0, 0, 1, 0, 0, 0, "mult_c5_done"));

    // Div: busy exactly 10 cycles; non-MD instructions pass through.
    cyc(mdv(1, 1, 0, 0, 0, 1, "div_c0"));
    for (int k = 1; k < 9; k++) cyc(mdv(0, 0, 0, 0, 0, 1, $sformatf("div_c%0d_nonmd", k)));
    cyc(mdv(0, 0, 1, 0, 1, 1, "div_c9_md"));
    cyc(mdv(0, 0, 1, 0, 0, 0, "div_c10_done"));

    // Restart while busy reloads the counter.
    cyc(mdv(1, 0, 0, 0, 0, 1, "reload_mult"));
    cyc(mdv(0, 0, 0, 0, 0, 1, "reload_c1"));
    cyc(mdv(1, 1, 0, 0, 0, 1, "reload_div"));
    for (int k = 1; k < 10; k++) cyc(mdv(0, 0, 0, 0, 0, 1, $sformatf("reload_div_c%0d", k)));
    cyc(mdv(0, 0, 1, 0, 0, 0, "reload_done"));

    // Reset mid-busy, and reset coincident with a start pulse.
    cyc(mdv(1, 1, 1, 0, 1, 1, "rst_div_c0"));
    cyc(mdv(0, 0, 1, 0, 1, 1, "rst_div_c1"));
    cyc(mdv(0, 0, 1, 0, 1, 1, "rst_div_c2"));
    cyc(mdv(0, 0, 1, 1, 0, 0, "rst_during_busy"));
    cyc(mdv(0, 0, 1, 0, 0, 0, "after_rst_idle"));
    cyc(mdv(1, 1, 1, 1, 0, 1, "rst_with_start"));
    cyc(mdv(0, 0, 1, 0, 0, 0, "rst_beats_start"));

    // 3 load-use stalls then 5 mult stalls; counter reads 8 afterwards (0 without the feature).
    cyc(tbl[0]); cyc(tbl[1]); cyc(tbl[8]);
    cyc(mdv(1, 0, 1, 0, 1, 1, "perf_mult_c0"));
    for (int k = 1; k < 5; k++) cyc(mdv(0, 0, 1, 0, 1, 1, $sformatf("perf_mult_c%0d", k)));
    cyc(mdv(0, 0, 0, 0, 0, 0, "perf_idle"));
    n_vec++;
`ifdef DE_STALL_PERF_EN
    if (stall_count !== 32'd8) begin
      n_fail++;
      $display("FAIL perf_count: got %0d, want 8", stall_count);
    end
`else
    if (stall_count !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_count_off: got %0d, want 0", stall_count);
    end
`endif
    cyc(mdv(0, 0, 0, 1, 0, 0, "perf_reset"));
    cyc(mdv(0, 0, 0, 0, 0, 0, "perf_after_reset"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/de_stall_ctrl.md
Name: de_stall_ctrl

Overview:
- Stall/flush controller that drives the enable and clear inputs of the D->E pipeline register, plus the PC and F->D register enables.
- Compares D-stage source operands and their Tuse against the E- and M-stage destinations and their Tnew, which E_Tnew from the D->E register feeds back.
- Tracks a multi-cycle mult/div unit with an internal busy counter and stalls D-stage MD instructions while it is busy.
- Sits between the D stage, the D->E register and the E-stage MDU start strobe.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult start, including the start cycle.
- DIV_CYCLES, 10: busy cycles after a div start, including the start cycle.
- CNT_W, 4: busy counter width; must satisfy max(MULT_CYCLES, DIV_CYCLES) < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- D_rs_addr  in  5  D-stage rs register number.
- D_rt_addr  in  5  D-stage rt register number.
- D_use_rs  in  1  D instruction reads rs.
- D_use_rt  in  1  D instruction reads rt.
- D_Tuse_rs  in  3  cycles until rs is needed.
- D_Tuse_rt  in  3  cycles until rt is needed.
- D_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_wa  in  5  E-stage destination register; 0 means none.
- E_Tnew  in  3  cycles until the E result is ready.
- M_wa  in  5  M-stage destination register.
- M_Tnew  in  3  cycles until the M result is ready.
- E_md_start  in  1  one-cycle pulse: mult/div issued in E.
- E_md_is_div  in  1  qualifies E_md_start: 1 means div, 0 means mult.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F->D register enable.
- de_en  out  1  D->E register enable.
- de_clr  out  1  D->E register clear (inserts a bubble).
- md_busy  out  1  MDU busy indication.
- stall_count  out  32  stall-cycle count (optional feature).

Behaviour:
- Data-hazard terms:
  - hz_rs = D_use_rs & (D_rs_addr != 0) & ((E_wa == D_rs_addr & E_Tnew > D_Tuse_rs) | (M_wa == D_rs_addr & M_Tnew > D_Tuse_rs)).
  - hz_rt is the same expression using the rt inputs.
  - Register 0 never hazards.
  - The comparison is unsigned, 3-bit.
- MD busy counter cnt (CNT_W bits, reset 0):
  - On E_md_start, cnt loads (E_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - Otherwise, cnt decrements when nonzero and holds at 0.
  - md_busy = E_md_start | (cnt != 0), combinational.
  - A new E_md_start while cnt != 0 reloads cnt. There is no queuing.
- hz_md = D_md & md_busy.
- stall = (hz_rs | hz_rt | hz_md) & ~reset.
- Outputs (combinational on stall):
  - pc_en = ~stall
  - fd_en = ~stall
  - de_en = 1
  - de_clr = stall
- A stall holds PC and the F->D register, and loads a NOP bubble into E.
- While reset is high: pc_en = fd_en = de_en = 1, de_clr = 0, md_busy reflects E_md_start only. On the next edge, cnt = 0 and stall_count = 0.
- Reset with E_md_start in the same cycle: reset wins and cnt = 0.
- Latency:
  - The stall decision is same-cycle and has no registered delay.
  - The counter effect is visible one cycle after start.
- Simultaneous data hazard and MD hazard: a single stall. The count increments by 1 per cycle.

Optional Feature:
- Macro: DE_STALL_PERF_EN.
- When defined:
  - stall_count is a 32-bit register, reset to 0.
  - It increments on every clock edge where stall = 1.
  - It wraps from 0xFFFFFFFF to 0.
- When undefined: stall_count is tied to 32'h0 and no register is synthesised.

Test Plan:
- Load-use hazard: E_wa=5, E_Tnew=2, D_rs_addr=5, D_use_rs=1, D_Tuse_rs=0 -> pc_en=0, fd_en=0, de_clr=1, de_en=1. Next cycle with E_Tnew=1, M_wa=5, M_Tnew=1 -> still stalled. Then M_Tnew=0 -> stall released.
- Forwardable case: E_wa=5, E_Tnew=1, D_Tuse_rt=1, D_rt_addr=5, D_use_rt=1 -> no stall, de_clr=0. Same case with D_rt_addr=0 and E_wa=0, E_Tnew=2 -> no stall.
- Mult: E_md_start=1, E_md_is_div=0 at cycle 0 with D_md=1 -> md_busy=1 for cycles 0..4 with stall. At cycle 5, md_busy=0 and pc_en=1.
- Div: E_md_start=1, E_md_is_div=1 -> md_busy held for exactly 10 cycles. A non-MD D instruction (D_md=0) during busy -> no stall.
- Reset mid-busy: start div, assert reset at cycle 3 -> outputs unstalled during reset, cnt=0 afterwards, md_busy=0 with E_md_start=0.
- With DE_STALL_PERF_EN: 3 load-use stall cycles plus 5 mult stall cycles -> stall_count=8. Reset -> 0. Without the macro, stall_count stays 0.
